// File: rtl/vital_sample_scheduler.sv
// vital_sample_scheduler: round-robin arbiter that shares one capture register
// among NUM_CH sensor channels. Each grant runs GRANT -> LOAD -> HOLD(HOLD_CYC) -> IDLE.
// Optional macro SCHED_CH0_PRIORITY_EN: channel 0 (alarm) wins whenever it requests.
module vital_sample_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int SIZE     = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*SIZE-1:0]    data_in,
    output logic [NUM_CH-1:0]         gnt,
    output logic [NUM_CH-1:0]         ack,
    output logic                      reg_en,
    output logic [SIZE-1:0]           reg_data,
    output logic [$clog2(NUM_CH)-1:0] reg_sel,
    output logic                      busy
);
    localparam int SW = $clog2(NUM_CH);
    localparam logic [SW-1:0] LAST_RST = SW'(NUM_CH - 1);
    // HOLD is never entered when HOLD_CYC=0, so the wrapped value is unused then
    localparam logic [3:0] HOLD_END = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOAD, HOLD} state_t;

    state_t            state, state_n;
    logic [SW-1:0]     win, win_n, last, last_n, rr_win;
    logic [3:0]        cnt, cnt_n;
    logic [NUM_CH-1:0] gnt_n, ack_n;
    logic              en_n, busy_n;
    logic [SIZE-1:0]   data_n;
    logic [SW-1:0]     sel_n;

    // Round-robin pick: first requester strictly after last, wrapping to 0
    always_comb begin
        int  idx;
        logic hit;
        rr_win = last;
        hit    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last) + k) % NUM_CH;
            if (!hit && req[idx[SW-1:0]]) begin
                hit    = 1'b1;
                rr_win = idx[SW-1:0];
            end
        end
`ifdef SCHED_CH0_PRIORITY_EN
        if (req[0]) rr_win = '0;
`endif
    end

    // Next state and next registered outputs; everything defaults to idle-low
    always_comb begin
        state_n = state;
        win_n   = win;
        last_n  = last;
        cnt_n   = cnt;
        gnt_n   = '0;
        ack_n   = '0;
        en_n    = 1'b0;
        data_n  = '0;
        sel_n   = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    win_n         = rr_win;
                    gnt_n[rr_win] = 1'b1;
                    state_n       = GRANT;
                end
            end
            GRANT: begin
                // data sampled at end of GRANT; winner already latched so a
                // dropped req cannot abort the transfer
                gnt_n[win] = 1'b1;
                ack_n[win] = 1'b1;
                en_n       = 1'b1;
                sel_n      = win;
                data_n     = data_in[int'(win)*SIZE +: SIZE];
                state_n    = LOAD;
            end
            LOAD: begin
                last_n  = win;
                cnt_n   = '0;
                state_n = (HOLD_CYC > 0) ? HOLD : IDLE;
            end
            HOLD: begin
                if (cnt == HOLD_END) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset discards any pending transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            win      <= '0;
            last     <= LAST_RST;
            cnt      <= '0;
            gnt      <= '0;
            ack      <= '0;
            reg_en   <= 1'b0;
            reg_data <= '0;
            reg_sel  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            win      <= win_n;
            last     <= last_n;
            cnt      <= cnt_n;
            gnt      <= gnt_n;
            ack      <= ack_n;
            reg_en   <= en_n;
            reg_data <= data_n;
            reg_sel  <= sel_n;
            busy     <= busy_n;
        end
    end
endmodule
